// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the ID-stage hazard unit and the pipeline registers it controls.
// The pipeline side drives the ID/EX and IF/ID observations; the unit drives the enables.
interface hazard_stall_unit_if;
   logic [31:0] Instruction_IN;
   logic        IDEX_MemRead;
   logic [4:0]  IDEX_RegT;
   logic        Branch_Taken;
   logic        PC_Write;
   logic        IFID_Write;
   logic        IDEX_Bubble;
   logic        IFID_Flush;
   logic [15:0] Stall_Total;
   logic [1:0]  State_Debug;

   modport master (
      output Instruction_IN, IDEX_MemRead, IDEX_RegT, Branch_Taken,
      input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Stall_Total, State_Debug
   );

   modport slave (
      input  Instruction_IN, IDEX_MemRead, IDEX_RegT, Branch_Taken,
      output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Stall_Total, State_Debug
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / taken-branch stall and flush generator for the ID stage of a 5-stage MIPS pipe,
// with a saturating count of load-use stall cycles for performance debug.
module hazard_stall_unit #(
   parameter int LOAD_STALL    = 1,
   parameter int BRANCH_SQUASH = 1
) (
   input logic CLOCK,
   input logic RESET,
   hazard_stall_unit_if.slave hs
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      SQUASH = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic [15:0] stall_total;
   logic        stall_cycle;
   logic        hazard;
   logic        rt_used;
   logic [5:0]  op;
   logic [4:0]  rs, rt;

   assign op = hs.Instruction_IN[31:26];
   assign rs = hs.Instruction_IN[25:21];
   assign rt = hs.Instruction_IN[20:16];

   // Only R-type, beq, bne and sw actually read rt as a source operand.
   assign rt_used = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
   assign hazard  = hs.IDEX_MemRead && (hs.IDEX_RegT != 5'd0) &&
                    ((hs.IDEX_RegT == rs) || (rt_used && (hs.IDEX_RegT == rt)));

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      stall_cycle    = 1'b0;
      hs.PC_Write    = 1'b1;
      hs.IFID_Write  = 1'b1;
      hs.IDEX_Bubble = 1'b0;
      hs.IFID_Flush  = 1'b0;

      case (state)
         RUN: begin
            if (hs.Branch_Taken) begin
               hs.IDEX_Bubble = 1'b1;
               hs.IFID_Flush  = 1'b1;
               if (BRANCH_SQUASH == 2) begin
                  state_nxt = SQUASH;
                  cnt_nxt   = 2'd1;
               end
            end else if (hazard) begin
               stall_cycle    = 1'b1;
               hs.PC_Write    = 1'b0;
               hs.IFID_Write  = 1'b0;
               hs.IDEX_Bubble = 1'b1;
               if (LOAD_STALL > 1) begin
                  state_nxt = STALL;
                  cnt_nxt   = 2'(LOAD_STALL - 2);
               end
            end
         end
         STALL: begin
            // A taken branch squashes the stalled instruction, so the stall is moot.
            if (hs.Branch_Taken) begin
               hs.IDEX_Bubble = 1'b1;
               hs.IFID_Flush  = 1'b1;
               state_nxt      = (BRANCH_SQUASH == 2) ? SQUASH : RUN;
               cnt_nxt        = (BRANCH_SQUASH == 2) ? 2'd1 : 2'd0;
            end else begin
               stall_cycle    = 1'b1;
               hs.PC_Write    = 1'b0;
               hs.IFID_Write  = 1'b0;
               hs.IDEX_Bubble = 1'b1;
               if (cnt == 2'd0) state_nxt = RUN;
               else             cnt_nxt   = cnt - 2'd1;
            end
         end
         SQUASH: begin
            hs.IDEX_Bubble = 1'b1;
            hs.IFID_Flush  = 1'b1;
            state_nxt      = RUN;
            cnt_nxt        = 2'd0;
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
         end
      endcase

      if (RESET) begin
         stall_cycle    = 1'b0;
         hs.PC_Write    = 1'b0;
         hs.IFID_Write  = 1'b0;
         hs.IDEX_Bubble = 1'b1;
         hs.IFID_Flush  = 1'b1;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state       <= RUN;
         cnt         <= 2'd0;
         stall_total <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (stall_cycle && (stall_total != 16'hFFFF)) stall_total <= stall_total + 16'd1;
      end
   end

   assign hs.Stall_Total = stall_total;
   assign hs.State_Debug = state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two configurations (1/1 and 3/2) share one stimulus stream and
// are checked every cycle against a cycle-count model, plus literal checks of directed scenarios.
module tb_hazard_stall_unit;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   bit   chk_en;

   hazard_stall_unit_if if_a ();
   hazard_stall_unit_if if_b ();

   hazard_stall_unit #(.LOAD_STALL(1), .BRANCH_SQUASH(1)) dut_a (
      .CLOCK (clk),
      .RESET (rst),
      .hs    (if_a)
   );

   hazard_stall_unit #(.LOAD_STALL(3), .BRANCH_SQUASH(2)) dut_b (
      .CLOCK (clk),
      .RESET (rst),
      .hs    (if_b)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_stall_left  [2];
   int m_squash_left [2];
   int m_total       [2];

   localparam logic [3:0] O_PASS  = 4'b1100;  // {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush}
   localparam logic [3:0] O_STALL = 4'b0010;
   localparam logic [3:0] O_FLUSH = 4'b1111;
   localparam logic [3:0] O_RESET = 4'b0011;

   function automatic bit model_hazard(input logic [31:0] ins, input logic mr, input logic [4:0] ld_rt);
      logic [5:0] o;
      bit         uses_rt;
      o       = ins[31:26];
      uses_rt = (o == 6'h00) || (o == 6'h04) || (o == 6'h05) || (o == 6'h2B);
      return mr && (ld_rt != 5'd0) && ((ld_rt == ins[25:21]) || (uses_rt && (ld_rt == ins[20:16])));
   endfunction

   task automatic model_cycle(input int idx, input int ls, input int bs,
                              input logic [31:0] ins, input logic mr, input logic [4:0] ld_rt,
                              input logic br, input logic [3:0] outs, input logic [15:0] tot);
      logic [3:0] exp;
      bit         stalled;
      stalled = 0;
      chk($sformatf("dut%0d_stall_total", idx), {16'd0, tot}, m_total[idx]);
      if (rst) begin
         exp                = O_RESET;
         m_stall_left[idx]  = 0;
         m_squash_left[idx] = 0;
         m_total[idx]       = 0;
      end else if (m_squash_left[idx] > 0) begin
         exp = O_FLUSH;
         m_squash_left[idx]--;
      end else if (br) begin
         exp                = O_FLUSH;
         m_stall_left[idx]  = 0;
         m_squash_left[idx] = bs - 1;
      end else if (m_stall_left[idx] > 0) begin
         exp     = O_STALL;
         stalled = 1;
         m_stall_left[idx]--;
      end else if (model_hazard(ins, mr, ld_rt)) begin
         exp               = O_STALL;
         stalled           = 1;
         m_stall_left[idx] = ls - 1;
      end else begin
         exp = O_PASS;
      end
      chk($sformatf("dut%0d_outputs", idx), {28'd0, outs}, {28'd0, exp});
      if (stalled && m_total[idx] < 65535) m_total[idx]++;
   endtask

   // ---------------- scoreboard: one compare per cycle ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         model_cycle(0, 1, 1, if_a.Instruction_IN, if_a.IDEX_MemRead, if_a.IDEX_RegT, if_a.Branch_Taken,
                     {if_a.PC_Write, if_a.IFID_Write, if_a.IDEX_Bubble, if_a.IFID_Flush}, if_a.Stall_Total);
         model_cycle(1, 3, 2, if_b.Instruction_IN, if_b.IDEX_MemRead, if_b.IDEX_RegT, if_b.Branch_Taken,
                     {if_b.PC_Write, if_b.IFID_Write, if_b.IDEX_Bubble, if_b.IFID_Flush}, if_b.Stall_Total);
      end
   end

   // ---------------- driver ----------------
   localparam logic [31:0] ADD_RS8 = 32'h010A4820;  // add $9,$8,$10
   localparam logic [31:0] LW_RT9  = 32'h8D490000;  // lw  $9,0($10)

   task automatic step(input logic r, input logic [31:0] ins, input logic mr,
                       input logic [4:0] ld_rt, input logic br);
      @(posedge clk);
      #1;
      rst                 = r;
      if_a.Instruction_IN = ins;
      if_b.Instruction_IN = ins;
      if_a.IDEX_MemRead   = mr;
      if_b.IDEX_MemRead   = mr;
      if_a.IDEX_RegT      = ld_rt;
      if_b.IDEX_RegT      = ld_rt;
      if_a.Branch_Taken   = br;
      if_b.Branch_Taken   = br;
      chk_en              = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      logic [5:0]  ops [6];
      logic [31:0] ins;
      checks   = 0;
      failures = 0;
      chk_en   = 1'b0;
      ops      = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};

      step(1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
      step(1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
      chk("reset_pc_write", {31'd0, if_a.PC_Write}, 32'd0);
      chk("reset_flush", {31'd0, if_b.IFID_Flush}, 32'd1);

      // load-use on rs
      step(1'b0, ADD_RS8, 1'b1, 5'd8, 1'b0);
      chk("a_rs_stall_pc", {31'd0, if_a.PC_Write}, 32'd0);
      chk("a_rs_stall_bubble", {31'd0, if_a.IDEX_Bubble}, 32'd1);
      chk("b_rs_stall_pc", {31'd0, if_b.PC_Write}, 32'd0);
      idle();
      chk("a_after_stall_pc", {31'd0, if_a.PC_Write}, 32'd1);
      chk("a_total_1", {16'd0, if_a.Stall_Total}, 32'd1);
      chk("b_stall2_pc", {31'd0, if_b.PC_Write}, 32'd0);
      idle();
      chk("b_stall3_pc", {31'd0, if_b.PC_Write}, 32'd0);
      chk("b_total_2", {16'd0, if_b.Stall_Total}, 32'd2);
      idle();
      chk("b_release_pc", {31'd0, if_b.PC_Write}, 32'd1);
      chk("b_total_3", {16'd0, if_b.Stall_Total}, 32'd3);

      // rt not a source for lw
      step(1'b0, LW_RT9, 1'b1, 5'd9, 1'b0);
      chk("a_lw_rt_pc", {31'd0, if_a.PC_Write}, 32'd1);
      chk("b_lw_rt_pc", {31'd0, if_b.PC_Write}, 32'd1);

      // branch beats hazard
      step(1'b0, ADD_RS8, 1'b1, 5'd8, 1'b1);
      chk("a_branch_flush", {31'd0, if_a.IFID_Flush}, 32'd1);
      chk("b_branch_flush1", {31'd0, if_b.IFID_Flush}, 32'd1);
      chk("b_branch_bubble1", {31'd0, if_b.IDEX_Bubble}, 32'd1);
      idle();
      chk("a_branch_done", {31'd0, if_a.IFID_Flush}, 32'd0);
      chk("b_branch_flush2", {31'd0, if_b.IFID_Flush}, 32'd1);
      chk("b_branch_bubble2", {31'd0, if_b.IDEX_Bubble}, 32'd1);
      chk("a_total_branch", {16'd0, if_a.Stall_Total}, 32'd1);
      idle();
      chk("b_branch_done", {31'd0, if_b.IFID_Flush}, 32'd0);
      chk("b_total_branch", {16'd0, if_b.Stall_Total}, 32'd3);

      // reset in the second stall cycle
      step(1'b0, ADD_RS8, 1'b1, 5'd8, 1'b0);
      step(1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
      chk("b_midreset_pc", {31'd0, if_b.PC_Write}, 32'd0);
      chk("b_midreset_flush", {31'd0, if_b.IFID_Flush}, 32'd1);
      chk("b_midreset_bubble", {31'd0, if_b.IDEX_Bubble}, 32'd1);
      idle();
      chk("b_postreset_pc", {31'd0, if_b.PC_Write}, 32'd1);
      chk("b_postreset_flush", {31'd0, if_b.IFID_Flush}, 32'd0);
      chk("b_postreset_total", {16'd0, if_b.Stall_Total}, 32'd0);
      chk("a_postreset_total", {16'd0, if_a.Stall_Total}, 32'd0);

      // randomized traffic, biased toward register collisions
      for (int i = 0; i < 3000; i++) begin
         ins = $urandom;
         ins[31:26] = ops[$urandom_range(0, 5)];
         ins[25:21] = 5'($urandom_range(0, 3));
         ins[20:16] = 5'($urandom_range(0, 3));
         step(($urandom_range(0, 99) == 0), ins, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      end

      // saturation: a held hazard stalls every cycle in both configurations
      step(1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 65540; i++) step(1'b0, ADD_RS8, 1'b1, 5'd8, 1'b0);
      idle();
      chk("a_saturated", {16'd0, if_a.Stall_Total}, 32'h0000FFFF);
      chk("b_saturated", {16'd0, if_b.Stall_Total}, 32'h0000FFFF);
      step(1'b0, ADD_RS8, 1'b1, 5'd8, 1'b0);
      idle();
      chk("a_saturated_hold", {16'd0, if_a.Stall_Total}, 32'h0000FFFF);
      chk("b_saturated_hold", {16'd0, if_b.Stall_Total}, 32'h0000FFFF);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
